// File: rtl/maj_vote_pkg.sv
// Shared constants, FSM state type and sizing helper for the five-way
// redundant channel voter.
package maj_vote_pkg;

  localparam int N_CH = 5;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    VOTE    = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  // Bits needed to hold a fault count that saturates at 'limit'.
  function automatic int cnt_width(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/maj5_bitvote.sv
// Combinational bitwise 3-of-5 majority; channels with a clear mask bit
// are treated as voting 0 on every bit.
module maj5_bitvote
  import maj_vote_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [N_CH*W-1:0] i_words,
  input  logic [N_CH-1:0]   i_mask,
  output logic [W-1:0]      o_vote
);

  genvar gi, gj;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit
      logic [N_CH-1:0] w_col;
      for (gj = 0; gj < N_CH; gj++) begin : g_ch
        assign w_col[gj] = i_mask[gj] & i_words[gj*W + gi];
      end
      assign o_vote[gi] = ($countones(w_col) >= 3);
    end
  endgenerate

endmodule

// File: rtl/maj5_vote_ctrl.sv
// Round sequencer for the five-way voter: collects one word per enabled
// channel, votes, presents the result and tracks per-channel faults.
module maj5_vote_ctrl
  import maj_vote_pkg::*;
#(
  parameter int W         = 8,
  parameter int TIMEOUT   = 15,
  parameter int ERR_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   ch_valid,
  input  logic [N_CH*W-1:0] ch_data,
  output logic [N_CH-1:0]   ch_ready,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  input  logic              out_ready,
  output logic [N_CH-1:0]   disagree,
  output logic [N_CH-1:0]   missing,
  output logic              degraded,
  output logic [N_CH-1:0]   ch_disabled,
  input  logic              clr_disable
);

  localparam int CW = cnt_width(ERR_LIMIT);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t            r_state, w_state_next;
  logic [N_CH-1:0]   r_captured, w_hs, w_cap_next, w_enabled, w_disagree;
  logic [W-1:0]      r_words [N_CH];
  logic [N_CH*W-1:0] w_words_flat;
  logic [TW-1:0]     r_timer;
  logic              w_close, w_out_hs;
  logic [W-1:0]      w_vote, r_out_data;
  logic [N_CH-1:0]   r_disagree, r_missing, r_disabled;
  logic              r_degraded;
  logic [CW-1:0]     r_cnt [N_CH];

  assign w_enabled = ~r_disabled;
  assign out_valid = (r_state == OUTPUT);
  assign w_out_hs  = out_valid & out_ready;

  always_comb begin
    w_state_next = r_state;
    ch_ready     = '0;
    w_hs         = '0;
    w_cap_next   = r_captured;
    w_close      = 1'b0;
    case (r_state)
      COLLECT: begin
        ch_ready   = ~r_captured & w_enabled;
        w_hs       = ch_valid & ~r_captured & w_enabled;
        w_cap_next = r_captured | w_hs;
        // An all-disabled block must never close a round on its own.
        w_close    = ((w_enabled != '0) && ((w_cap_next & w_enabled) == w_enabled))
                  || ((r_captured != '0) && (r_timer == TW'(TIMEOUT - 1)));
        if (w_close) w_state_next = VOTE;
      end
      VOTE:    w_state_next = OUTPUT;
      OUTPUT:  if (out_ready) w_state_next = COLLECT;
      default: w_state_next = COLLECT;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      assign w_words_flat[gi*W +: W] = r_words[gi];
      assign w_disagree[gi] = r_captured[gi] && (r_words[gi] != w_vote);
    end
  endgenerate

  maj5_bitvote #(.W(W)) u_bitvote (
    .i_words (w_words_flat),
    .i_mask  (r_captured),
    .o_vote  (w_vote)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= COLLECT;
      r_captured <= '0;
      r_timer    <= '0;
      r_out_data <= '0;
      r_disagree <= '0;
      r_missing  <= '0;
      r_degraded <= 1'b0;
      for (int i = 0; i < N_CH; i++) r_words[i] <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        COLLECT: begin
          r_captured <= w_cap_next;
          for (int i = 0; i < N_CH; i++)
            if (w_hs[i]) r_words[i] <= ch_data[i*W +: W];
          if ((r_captured == '0) && (w_hs != '0)) r_timer <= '0;
          else if (r_captured != '0)              r_timer <= r_timer + TW'(1);
        end
        VOTE: begin
          r_out_data <= w_vote;
          r_disagree <= w_disagree;
          r_missing  <= ~r_captured & w_enabled;
          r_degraded <= ($countones(r_captured) < 3);
        end
        OUTPUT: if (out_ready) r_captured <= '0;
        default: ;
      endcase
    end
  end

  // Fault counters; a clear request overrides a same-cycle update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_disabled <= '0;
      for (int i = 0; i < N_CH; i++) r_cnt[i] <= '0;
    end else if (clr_disable) begin
      r_disabled <= '0;
      for (int i = 0; i < N_CH; i++) r_cnt[i] <= '0;
    end else if (w_out_hs) begin
      for (int i = 0; i < N_CH; i++) begin
        if (!r_disabled[i]) begin
          if (r_disagree[i] || r_missing[i]) begin
            if (r_cnt[i] >= CW'(ERR_LIMIT - 1)) begin
              r_cnt[i]      <= CW'(ERR_LIMIT);
              r_disabled[i] <= 1'b1;
            end else begin
              r_cnt[i] <= r_cnt[i] + CW'(1);
            end
          end else begin
            r_cnt[i] <= '0;
          end
        end
      end
    end
  end

  assign out_data    = r_out_data;
  assign disagree    = r_disagree;
  assign missing     = r_missing;
  assign degraded    = r_degraded;
  assign ch_disabled = r_disabled;

endmodule
